// File: rtl/stream_distributor_flushable.sv
// 1-to-N_OUP stream distributor: each beat is steered by inp_sel_i into a per-output FIFO; flush_i empties all FIFOs.
// Optional STREAM_DISTR_DROP_CNT_EN adds drop_cnt_o, a saturating count of beats lost to flush or out-of-range select.

module stream_distributor_fifo #(
  parameter type DATA_T = logic,
  parameter int  DEPTH  = 2,
  parameter int  PW     = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  DATA_T         data_i,
  input  logic          pop_i,
  output DATA_T         data_o,
  output logic          empty_o,
  output logic [PW-1:0] occ_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = (AW > 0) ? AW : 1;
  localparam logic [IW-1:0] IDX_MASK = IW'(DEPTH - 1);

  DATA_T [DEPTH-1:0] mem;
  logic [PW-1:0] wptr, rptr;
  logic [IW-1:0] widx, ridx;

  // Pointers carry one extra MSB so full and empty differ; the mask keeps DEPTH=1 legal.
  assign widx    = IW'(wptr) & IDX_MASK;
  assign ridx    = IW'(rptr) & IDX_MASK;
  assign occ_o   = wptr - rptr;
  assign empty_o = (wptr == rptr);
  assign data_o  = mem[ridx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      mem  <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_i) begin
        mem[widx] <= data_i;
        wptr      <= wptr + 1'b1;
      end
      if (pop_i) rptr <= rptr + 1'b1;
    end
  end
endmodule

module stream_distributor_flushable #(
  parameter type DATA_T = logic,
  parameter int  N_OUP  = 2,
  parameter int  DEPTH  = 2,
  parameter int  SEL_W  = $clog2(N_OUP)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  DATA_T                 inp_data_i,
  input  logic [SEL_W-1:0]      inp_sel_i,
  input  logic                  inp_valid_i,
  output logic                  inp_ready_o,
  output DATA_T [N_OUP-1:0]     oup_data_o,
  output logic [N_OUP-1:0]      oup_valid_o,
  input  logic [N_OUP-1:0]      oup_ready_i
`ifdef STREAM_DISTR_DROP_CNT_EN
  ,
  output logic [15:0]           drop_cnt_o
`endif
);
  localparam int PW   = $clog2(DEPTH) + 1;
  localparam int SELN = 2 ** SEL_W;

  logic [N_OUP-1:0]         full, empty, push, pop;
  logic [N_OUP-1:0][PW-1:0] occ;
  logic [SELN-1:0]          full_ext;
  logic                     sel_oor, accept;

  // Out-of-range selects are accepted and dropped; full_ext pads the unused indices.
  assign sel_oor     = ({1'b0, inp_sel_i} >= (SEL_W+1)'(N_OUP));
  assign full_ext    = SELN'(full);
  assign inp_ready_o = rst_ni && !flush_i && (sel_oor || !full_ext[inp_sel_i]);
  assign accept      = inp_valid_i && inp_ready_o;

  for (genvar i = 0; i < N_OUP; i++) begin : g_oup
    assign push[i]        = accept && (inp_sel_i == SEL_W'(i));
    assign full[i]        = (occ[i] == PW'(DEPTH));
    assign oup_valid_o[i] = !empty[i];
    assign pop[i]         = oup_valid_o[i] && oup_ready_i[i];

    stream_distributor_fifo #(
      .DATA_T (DATA_T),
      .DEPTH  (DEPTH),
      .PW     (PW)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push[i]),
      .data_i  (inp_data_i),
      .pop_i   (pop[i]),
      .data_o  (oup_data_o[i]),
      .empty_o (empty[i]),
      .occ_o   (occ[i])
    );
  end

`ifdef STREAM_DISTR_DROP_CNT_EN
  logic [16:0] drop_add;
  logic [17:0] drop_sum;

  // Beats handed out during the flush cycle were delivered, so they are not drops.
  always_comb begin
    drop_add = '0;
    if (flush_i) begin
      for (int i = 0; i < N_OUP; i++)
        drop_add = drop_add + 17'(occ[i]) - 17'(pop[i]);
    end else if (accept && sel_oor) begin
      drop_add = 17'd1;
    end
  end

  assign drop_sum = 18'(drop_cnt_o) + 18'(drop_add);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              drop_cnt_o <= '0;
    else if (drop_add != '0)  drop_cnt_o <= (drop_sum > 18'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
  end
`endif
endmodule

// File: tb/tb_stream_distributor_flushable.sv
// Directed vector table plus hand sequences and a queue-model random run for stream_distributor_flushable.
module tb_stream_distributor_flushable;
  logic            clk, rst_n, flush;
  logic [7:0]      in_data;
  logic [1:0]      in_sel;
  logic            in_valid, in_ready;
  logic [3:0][7:0] oup_data;
  logic [3:0]      oup_valid, oup_ready;

  logic [7:0]      d3_data;
  logic [1:0]      d3_sel;
  logic            d3_valid, d3_in_ready;
  logic [2:0][7:0] d3_oup_data;
  logic [2:0]      d3_oup_valid, d3_oup_ready;
`ifdef STREAM_DISTR_DROP_CNT_EN
  logic [15:0]     drop_cnt, d3_drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  stream_distributor_flushable #(.DATA_T(logic [7:0]), .N_OUP(4), .DEPTH(2)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .inp_data_i  (in_data),
    .inp_sel_i   (in_sel),
    .inp_valid_i (in_valid),
    .inp_ready_o (in_ready),
    .oup_data_o  (oup_data),
    .oup_valid_o (oup_valid),
    .oup_ready_i (oup_ready)
`ifdef STREAM_DISTR_DROP_CNT_EN
    ,
    .drop_cnt_o  (drop_cnt)
`endif
  );

  // Three outputs leave select value 3 unused, which exercises the out-of-range path.
  stream_distributor_flushable #(.DATA_T(logic [7:0]), .N_OUP(3), .DEPTH(2)) u_dut3 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (1'b0),
    .inp_data_i  (d3_data),
    .inp_sel_i   (d3_sel),
    .inp_valid_i (d3_valid),
    .inp_ready_o (d3_in_ready),
    .oup_data_o  (d3_oup_data),
    .oup_valid_o (d3_oup_valid),
    .oup_ready_i (d3_oup_ready)
`ifdef STREAM_DISTR_DROP_CNT_EN
    ,
    .drop_cnt_o  (d3_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [1:0] sel;
    logic [7:0] d;
    logic [3:0] rdy;
    logic       fl;
    logic       exp_ir;
    logic [3:0] exp_ov;
    int         lane;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] q[4][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic [1:0] sel, input logic [7:0] d, input logic [3:0] rdy,
                     input logic fl, input logic exp_ir, input logic [3:0] exp_ov, input int lane,
                     input logic [7:0] exp_d);
    vec_t v;
    v.vld = vld; v.sel = sel; v.d = d; v.rdy = rdy; v.fl = fl;
    v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.lane = lane; v.exp_d = exp_d;
    vecs.push_back(v);
  endtask

  initial begin
    int beats = 0;
    rst_n = 1'b0; flush = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0; oup_ready = '0;
    d3_data = '0; d3_sel = '0; d3_valid = 1'b0; d3_oup_ready = '0;

    //  vld sel  data   rdy     fl  ir  ov      lane data
    add(1, 2, 8'hA5, 4'b1111, 0, 1, 4'b0000, -1, 8'h00);  // single beat to output 2
    add(1, 2, 8'hB6, 4'b1111, 0, 1, 4'b0100,  2, 8'hA5);
    add(0, 2, 8'h00, 4'b1111, 0, 1, 4'b0100,  2, 8'hB6);
    add(0, 2, 8'h00, 4'b1111, 0, 1, 4'b0000, -1, 8'h00);
    add(1, 1, 8'h11, 4'b1101, 0, 1, 4'b0000, -1, 8'h00);  // output 1 stalled
    add(1, 1, 8'h22, 4'b1101, 0, 1, 4'b0010,  1, 8'h11);
    add(1, 1, 8'h33, 4'b1101, 0, 0, 4'b0010,  1, 8'h11);
    add(1, 3, 8'h44, 4'b1101, 0, 1, 4'b0010,  1, 8'h11);
    add(0, 3, 8'h00, 4'b1101, 0, 1, 4'b1010,  3, 8'h44);
    add(0, 3, 8'h00, 4'b1111, 0, 1, 4'b0010,  1, 8'h11);
    add(0, 3, 8'h00, 4'b1111, 0, 1, 4'b0010,  1, 8'h22);
    add(0, 3, 8'h00, 4'b1111, 0, 1, 4'b0000, -1, 8'h00);
    add(1, 0, 8'h11, 4'b1110, 0, 1, 4'b0000, -1, 8'h00);  // fill output 0 then flush
    add(1, 0, 8'h22, 4'b1110, 0, 1, 4'b0001,  0, 8'h11);
    add(0, 0, 8'h00, 4'b1110, 0, 0, 4'b0001,  0, 8'h11);
    add(1, 0, 8'h99, 4'b1110, 1, 0, 4'b0001,  0, 8'h11);
    add(0, 0, 8'h00, 4'b1110, 0, 1, 4'b0000, -1, 8'h00);
    add(1, 2, 8'h55, 4'b1111, 1, 0, 4'b0000, -1, 8'h00);  // flush held two cycles
    add(1, 2, 8'h55, 4'b1111, 1, 0, 4'b0000, -1, 8'h00);
    add(0, 2, 8'h00, 4'b1111, 0, 1, 4'b0000, -1, 8'h00);
    add(1, 0, 8'hAA, 4'b1110, 0, 1, 4'b0000, -1, 8'h00);  // full blocks push even while popping
    add(1, 0, 8'hBB, 4'b1110, 0, 1, 4'b0001,  0, 8'hAA);
    add(1, 0, 8'hCC, 4'b1111, 0, 0, 4'b0001,  0, 8'hAA);
    add(1, 0, 8'hCC, 4'b1110, 0, 1, 4'b0001,  0, 8'hBB);
    add(0, 0, 8'h00, 4'b1111, 0, 0, 4'b0001,  0, 8'hBB);
    add(0, 0, 8'h00, 4'b1111, 0, 1, 4'b0001,  0, 8'hCC);
    add(0, 0, 8'h00, 4'b1111, 0, 1, 4'b0000, -1, 8'h00);

    #3;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(oup_valid), 32'd0);
    chk("rst_data",  32'(oup_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      in_valid = vecs[k].vld; in_sel = vecs[k].sel; in_data = vecs[k].d;
      oup_ready = vecs[k].rdy; flush = vecs[k].fl;
      #1;
      chk($sformatf("v%0d_ready", k), 32'(in_ready), 32'(vecs[k].exp_ir));
      chk($sformatf("v%0d_valid", k), 32'(oup_valid), 32'(vecs[k].exp_ov));
      if (vecs[k].lane >= 0)
        chk($sformatf("v%0d_data", k), 32'(oup_data[vecs[k].lane]), 32'(vecs[k].exp_d));
    end
`ifdef STREAM_DISTR_DROP_CNT_EN
    chk("flush_drop_cnt", 32'(drop_cnt), 32'd2);
`endif

    // Asynchronous reset with beats queued on output 1.
    @(negedge clk); in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h77; oup_ready = 4'b0000; flush = 1'b0;
    @(negedge clk); in_data = 8'h78;
    @(negedge clk); in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(oup_valid), 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(oup_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_valid", 32'(oup_valid), 32'd0);
    @(negedge clk); #1;
    chk("post_rst_valid2", 32'(oup_valid), 32'd0);

    // Out-of-range select on the three-output instance.
    @(negedge clk); d3_valid = 1'b1; d3_sel = 2'd3; d3_data = 8'h5A; d3_oup_ready = 3'b111;
    #1;
    chk("oor_ready", 32'(d3_in_ready), 32'd1);
    @(negedge clk); d3_sel = 2'd2; d3_data = 8'h6B;
    #1;
    chk("oor_no_valid", 32'(d3_oup_valid), 32'd0);
    @(negedge clk); d3_valid = 1'b0;
    #1;
    chk("d3_valid", 32'(d3_oup_valid), 32'b100);
    chk("d3_data", 32'(d3_oup_data[2]), 32'h6B);
`ifdef STREAM_DISTR_DROP_CNT_EN
    chk("oor_drop_cnt", 32'(d3_drop_cnt), 32'd1);
`endif

    // Random traffic against a per-output queue model with occasional flushes.
    for (int c = 0; c < 16000; c++) begin
      logic [3:0] exp_ov;
      logic       exp_ir;
      @(negedge clk);
      flush     = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom_range(0, 255));
      for (int i = 0; i < 4; i++) oup_ready[i] = ($urandom_range(0, 3) != 0);
      #1;
      for (int i = 0; i < 4; i++) begin
        exp_ov[i] = (q[i].size() != 0);
        if (exp_ov[i]) chk("rand_data", 32'(oup_data[i]), 32'(q[i][0]));
      end
      chk("rand_valid", 32'(oup_valid), 32'(exp_ov));
      exp_ir = !flush && (q[in_sel].size() < 2);
      chk("rand_ready", 32'(in_ready), 32'(exp_ir));
      if (flush) begin
        for (int i = 0; i < 4; i++) q[i].delete();
      end else begin
        for (int i = 0; i < 4; i++)
          if (exp_ov[i] && oup_ready[i]) void'(q[i].pop_front());
        if (in_valid && exp_ir) begin
          q[in_sel].push_back(in_data);
          beats++;
        end
      end
    end
    chk("rand_beats_min", 32'(beats > 8000), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
